// File: rtl/processor_pkg.sv
// processor_pkg: target-id type and default address map shared by the instruction bus demux.
package processor_pkg;
    localparam int MAX_TARGETS = 8;
    localparam int CNT_W = 4;
    // one id beyond the last real target is reserved for the internal error responder
    typedef logic [$clog2(MAX_TARGETS + 1)-1:0] tgt_id_t;
    localparam logic [31:0] DEF_TGT_BASE [2] = '{32'h0000_0000, 32'h8000_0000};
    localparam logic [31:0] DEF_TGT_MASK [2] = '{32'hFFFF_F000, 32'hFFFF_0000};
endpackage

// File: rtl/instr_txn_tracker.sv
// instr_txn_tracker: counts granted-but-unanswered transactions and remembers which target owns them.
module instr_txn_tracker
    import processor_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_grant,
    input  tgt_id_t          i_grant_id,
    input  logic             i_resp,
    output logic [CNT_W-1:0] o_count,
    output tgt_id_t          o_active_id
);
    logic [CNT_W-1:0] r_count;
    tgt_id_t          r_active_id;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count     <= '0;
            r_active_id <= '0;
        end else begin
            if (i_grant && !i_resp && r_count < CNT_W'(MAX_OUTSTANDING))
                r_count <= r_count + 1'b1;
            else if (i_resp && !i_grant && r_count != '0)
                r_count <= r_count - 1'b1;
            if (i_grant)
                r_active_id <= i_grant_id;
        end
    end

    assign o_count     = r_count;
    assign o_active_id = r_active_id;
endmodule

// File: rtl/instr_bus_demux.sv
// instr_bus_demux: routes one instruction-fetch initiator to N address-decoded targets,
// keeping responses in order by only issuing to a new target once the bus has drained.
module instr_bus_demux
    import processor_pkg::*;
#(
    parameter int          NUM_TARGETS     = 2,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [31:0] TGT_BASE [NUM_TARGETS] = DEF_TGT_BASE,
    parameter logic [31:0] TGT_MASK [NUM_TARGETS] = DEF_TGT_MASK
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        instr_req_i,
    input  logic [31:0]                 instr_addr_i,
    output logic                        instr_gnt_o,
    output logic                        instr_rvalid_o,
    output logic [31:0]                 instr_rdata_o,
    output logic                        instr_err_o,
    output logic [NUM_TARGETS-1:0]      tgt_req_o,
    output logic [NUM_TARGETS-1:0][31:0] tgt_addr_o,
    input  logic [NUM_TARGETS-1:0]      tgt_gnt_i,
    input  logic [NUM_TARGETS-1:0]      tgt_rvalid_i,
    input  logic [NUM_TARGETS-1:0][31:0] tgt_rdata_i,
    input  logic [NUM_TARGETS-1:0]      tgt_err_i,
    output logic                        proto_err_o
);
    localparam tgt_id_t ERR_ID = tgt_id_t'(NUM_TARGETS);

    tgt_id_t          w_sel;
    tgt_id_t          w_active_id;
    logic [CNT_W-1:0] w_count;
    logic             w_sel_gnt;
    logic             w_busy;
    logic             w_block;
    logic             w_allow;
    logic             w_issue;
    logic             w_grant;
    logic             w_rvalid;
    logic             w_rerr;
    logic [31:0]      w_rdata;
    logic             w_bad;
    logic             r_err_pend;
    logic             r_rst_hold;
    logic             r_proto_err;

    // descending scan so the lowest hitting index is the one left standing
    always_comb begin
        w_sel = ERR_ID;
        for (int i = NUM_TARGETS - 1; i >= 0; i--)
            if ((instr_addr_i & TGT_MASK[i]) == TGT_BASE[i])
                w_sel = tgt_id_t'(i);
        w_sel_gnt = (w_sel == ERR_ID);
        for (int i = 0; i < NUM_TARGETS; i++)
            if (w_sel == tgt_id_t'(i))
                w_sel_gnt = tgt_gnt_i[i];
    end

    assign w_busy  = (w_count != '0);
    assign w_block = rst | r_rst_hold;
    assign w_allow = !w_block && (w_count < CNT_W'(MAX_OUTSTANDING)) && (!w_busy || w_sel == w_active_id);
    assign w_issue = instr_req_i && w_allow;
    assign w_grant = w_issue && w_sel_gnt;

    always_comb begin
        tgt_req_o  = '0;
        tgt_addr_o = '0;
        for (int i = 0; i < NUM_TARGETS; i++) begin
            tgt_req_o[i]  = w_issue && (w_sel == tgt_id_t'(i));
            tgt_addr_o[i] = instr_addr_i;
        end
    end

    always_comb begin
        w_rvalid = 1'b0;
        w_rdata  = '0;
        w_rerr   = 1'b0;
        w_bad    = 1'b0;
        for (int i = 0; i < NUM_TARGETS; i++) begin
            if (w_busy && w_active_id == tgt_id_t'(i)) begin
                w_rvalid = tgt_rvalid_i[i];
                w_rdata  = tgt_rdata_i[i];
                w_rerr   = tgt_err_i[i];
            end else if (tgt_rvalid_i[i]) begin
                w_bad = 1'b1;
            end
        end
        if (w_busy && w_active_id == ERR_ID) begin
            w_rvalid = r_err_pend;
            w_rerr   = 1'b1;
        end
    end

    assign instr_gnt_o    = w_grant;
    assign instr_rvalid_o = w_rvalid && !rst;
    assign instr_rdata_o  = instr_rvalid_o ? w_rdata : '0;
    assign instr_err_o    = instr_rvalid_o && w_rerr;
    assign proto_err_o    = r_proto_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_pend  <= 1'b0;
            r_proto_err <= 1'b0;
            r_rst_hold  <= 1'b1;
        end else begin
            r_err_pend  <= w_grant && (w_sel == ERR_ID);
            r_proto_err <= r_proto_err | w_bad;
            r_rst_hold  <= 1'b0;
        end
    end

    instr_txn_tracker #(
        .MAX_OUTSTANDING(MAX_OUTSTANDING)
    ) u_tracker (
        .clk        (clk),
        .rst        (rst),
        .i_grant    (w_grant),
        .i_grant_id (w_sel),
        .i_resp     (instr_rvalid_o),
        .o_count    (w_count),
        .o_active_id(w_active_id)
    );
endmodule

// File: tb/tb_instr_bus_demux.sv
// tb_instr_bus_demux: directed scenarios then random traffic, checked against a transaction-level
// model (in-order response queue plus queued target responders).
module tb_instr_bus_demux;
    localparam int NT = 2;
    localparam int MO = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic                instr_req_i;
    logic [31:0]         instr_addr_i;
    logic                instr_gnt_o;
    logic                instr_rvalid_o;
    logic [31:0]         instr_rdata_o;
    logic                instr_err_o;
    logic [NT-1:0]       tgt_req_o;
    logic [NT-1:0][31:0] tgt_addr_o;
    logic [NT-1:0]       tgt_gnt_i;
    logic [NT-1:0]       tgt_rvalid_i;
    logic [NT-1:0][31:0] tgt_rdata_i;
    logic [NT-1:0]       tgt_err_i;
    logic                proto_err_o;

    always #5 clk = ~clk;

    instr_bus_demux #(.NUM_TARGETS(NT), .MAX_OUTSTANDING(MO)) dut (
        .clk           (clk),
        .rst           (rst),
        .instr_req_i   (instr_req_i),
        .instr_addr_i  (instr_addr_i),
        .instr_gnt_o   (instr_gnt_o),
        .instr_rvalid_o(instr_rvalid_o),
        .instr_rdata_o (instr_rdata_o),
        .instr_err_o   (instr_err_o),
        .tgt_req_o     (tgt_req_o),
        .tgt_addr_o    (tgt_addr_o),
        .tgt_gnt_i     (tgt_gnt_i),
        .tgt_rvalid_i  (tgt_rvalid_i),
        .tgt_rdata_i   (tgt_rdata_i),
        .tgt_err_i     (tgt_err_i),
        .proto_err_o   (proto_err_o)
    );

    int checks = 0;
    int failures = 0;

    logic [32:0] sb [$];
    logic [32:0] tq [NT][$];
    int          act = 0;
    bit          errp = 0;
    bit          perr = 0;
    bit          hold = 0;
    bit          pv [NT];

    function automatic int decode(input logic [31:0] a);
        if (a[31:12] == 20'h0) return 0;
        if (a[31:16] == 16'h8000) return 1;
        return NT;
    endfunction

    function automatic logic [32:0] tdata(input int i, input logic [31:0] a);
        return {a[3] & a[2], a ^ (i == 0 ? 32'hDEADBEFF : 32'h0F0F_1234)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic req, input logic [31:0] addr, input logic [NT-1:0] g,
                        input logic [NT-1:0] en, input logic [NT-1:0] inj, input string tag);
        int          sel;
        int          n;
        bit          allow;
        bit          egnt;
        bit          erv;
        bit          bad;
        logic [NT-1:0] ereq;
        logic [32:0] eword;
        instr_req_i  = req;
        instr_addr_i = addr;
        tgt_gnt_i    = g;
        for (int i = 0; i < NT; i++) begin
            pv[i]           = en[i] && tq[i].size() > 0;
            tgt_rvalid_i[i] = pv[i] | inj[i];
            tgt_rdata_i[i]  = pv[i] ? tq[i][0][31:0] : $urandom();
            tgt_err_i[i]    = pv[i] ? tq[i][0][32] : 1'($urandom());
        end
        #1;
        sel   = decode(addr);
        n     = sb.size();
        allow = !rst && !hold && n < MO && (n == 0 || sel == act);
        egnt  = req && allow && (sel == NT || g[sel]);
        ereq  = '0;
        if (req && allow && sel < NT) ereq[sel] = 1'b1;
        erv   = !rst && n > 0 && (act == NT ? errp : pv[act]);
        eword = erv ? sb[0] : 33'h0;
        bad   = 0;
        for (int i = 0; i < NT; i++)
            if ((pv[i] | inj[i]) && !(n > 0 && act == i)) bad = 1;
        chk({tag, ".req"}, 64'(tgt_req_o), 64'(ereq));
        chk({tag, ".gnt"}, 64'(instr_gnt_o), 64'(egnt));
        chk({tag, ".rvalid"}, 64'(instr_rvalid_o), 64'(erv));
        chk({tag, ".rdata"}, 64'(instr_rdata_o), 64'(eword[31:0]));
        chk({tag, ".err"}, 64'(instr_err_o), 64'(eword[32]));
        chk({tag, ".proto"}, 64'(proto_err_o), 64'(perr));
        chk({tag, ".addr"}, 64'(tgt_addr_o), {addr, addr});
        @(posedge clk);
        for (int i = 0; i < NT; i++) begin
            if (pv[i]) void'(tq[i].pop_front());
            if (egnt && sel == i) tq[i].push_back(tdata(i, addr));
        end
        if (rst) begin
            sb.delete();
            act  = 0;
            errp = 0;
            perr = 0;
            hold = 1;
        end else begin
            hold = 0;
            perr = perr | bad;
            if (erv) void'(sb.pop_front());
            errp = egnt && sel == NT;
            if (egnt) begin
                act = sel;
                sb.push_back(sel == NT ? {1'b1, 32'h0} : tdata(sel, addr));
            end
        end
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] a;
        rst = 1'b1;
        instr_req_i = 1'b0;
        instr_addr_i = '0;
        tgt_gnt_i = '0;
        tgt_rvalid_i = '0;
        tgt_rdata_i = '0;
        tgt_err_i = '0;
        @(negedge clk);
        step(1, 32'h10, 2'b11, 2'b00, 2'b00, "in_rst");
        rst = 1'b0;
        step(1, 32'h10, 2'b11, 2'b00, 2'b00, "post_rst");
        // single read to target 0
        step(1, 32'h0000_0010, 2'b01, 2'b00, 2'b00, "t0_req");
        step(0, 32'h0, 2'b00, 2'b01, 2'b00, "t0_resp");
        // unmapped address
        step(1, 32'h4000_0000, 2'b11, 2'b00, 2'b00, "unmap_req");
        step(0, 32'h0, 2'b00, 2'b00, 2'b00, "unmap_resp");
        // outstanding limit
        step(1, 32'h100, 2'b01, 2'b00, 2'b00, "lim_a");
        step(1, 32'h104, 2'b01, 2'b00, 2'b00, "lim_b");
        step(1, 32'h108, 2'b01, 2'b00, 2'b00, "lim_stall");
        step(1, 32'h108, 2'b01, 2'b01, 2'b00, "lim_resp1");
        step(1, 32'h108, 2'b01, 2'b00, 2'b00, "lim_c");
        step(0, 32'h0, 2'b00, 2'b01, 2'b00, "lim_resp2");
        step(0, 32'h0, 2'b00, 2'b01, 2'b00, "lim_resp3");
        // switching target must wait for drain
        step(1, 32'h20, 2'b01, 2'b00, 2'b00, "sw_t0");
        step(1, 32'h8000_0000, 2'b11, 2'b00, 2'b00, "sw_stall");
        step(1, 32'h8000_0000, 2'b11, 2'b01, 2'b00, "sw_t0_resp");
        step(1, 32'h8000_0000, 2'b11, 2'b00, 2'b00, "sw_t1");
        step(0, 32'h0, 2'b00, 2'b10, 2'b00, "sw_t1_resp");
        // stray response while idle
        step(0, 32'h0, 2'b00, 2'b00, 2'b10, "stray");
        step(0, 32'h0, 2'b00, 2'b00, 2'b00, "stray_sticky");
        step(1, 32'h30, 2'b01, 2'b01, 2'b00, "sticky_req");
        step(0, 32'h0, 2'b00, 2'b01, 2'b00, "sticky_resp");
        // reset with two outstanding
        step(1, 32'h200, 2'b01, 2'b00, 2'b00, "mid_a");
        step(1, 32'h204, 2'b01, 2'b00, 2'b00, "mid_b");
        rst = 1'b1;
        step(1, 32'h300, 2'b01, 2'b01, 2'b00, "mid_rst");
        rst = 1'b0;
        step(1, 32'h300, 2'b01, 2'b00, 2'b00, "mid_hold");
        step(0, 32'h0, 2'b00, 2'b01, 2'b00, "late_resp");
        step(1, 32'h400, 2'b01, 2'b00, 2'b00, "after_req");
        step(0, 32'h0, 2'b00, 2'b01, 2'b00, "after_resp");
        rst = 1'b1;
        step(0, 32'h0, 2'b00, 2'b00, 2'b00, "rst2");
        rst = 1'b0;
        for (int k = 0; k < 400; k++) begin
            case ($urandom_range(0, 2))
                0: a = {20'h0, 12'($urandom())};
                1: a = {16'h8000, 16'($urandom())};
                default: a = 32'h4000_0000 | 32'($urandom_range(0, 32'hFFFF));
            endcase
            step(1'($urandom()), a, 2'($urandom()), 2'($urandom()), 2'b00, "rand");
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
